// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the I/D line-fetch arbiter.
// Holds the arbiter state encoding and the cache-line offset width.
package rv32i_types;

   localparam int OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_t;

   // Clears the byte-within-line bits so downstream always sees a line address.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~((32'd1 << OFFSET_W) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and downstream memory bus bundle.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int LINE_W = 256
);
   logic              i_read;
   logic [31:0]       i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [31:0]       d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [31:0]       pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface

// File: rtl/mem_arbiter_wait_ctr.sv
// rtl/mem_arbiter_wait_ctr.sv - saturating grant-duration counter.
// Cleared at each grant, counts grant cycles, sticks at MAX_WAIT.
module arb_wait_ctr #(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign at_max = (count_q == CNT_W'(MAX_WAIT));
   assign count  = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && !at_max) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter for I/D cache line traffic.
// One downstream transaction at a time; responses pass straight through.
module mem_arbiter
   import rv32i_types::*;
#(
   parameter int LINE_W   = 256,
   parameter int MAX_WAIT = 255
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          timeout_err
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_t        state_q;
   logic              last_d_q;
   logic              pmem_read_q;
   logic              pmem_write_q;
   logic [31:0]       pmem_address_q;
   logic [LINE_W-1:0] pmem_wdata_q;
   logic              timeout_err_q;

   logic              i_pend;
   logic              d_pend;
   logic              pick_i;
   logic              pick_d;
   logic              in_grant;
   logic              ctr_at_max;
   logic [CNT_W-1:0]  ctr_count;

   assign i_pend   = bus.i_read;
   assign d_pend   = bus.d_read | bus.d_write;
   // last_d_q=1 means D went last, so I wins a tie.
   assign pick_i   = (state_q == IDLE) && i_pend && (!d_pend || last_d_q);
   assign pick_d   = (state_q == IDLE) && d_pend && !pick_i;
   assign in_grant = (state_q != IDLE);

   arb_wait_ctr #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_wait_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (pick_i | pick_d),
      .en     (in_grant & ~ctr_at_max),
      .count  (ctr_count),
      .at_max (ctr_at_max)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         last_d_q       <= 1'b1;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         timeout_err_q  <= 1'b0;
      end else begin
         // Flag rises on the same edge the counter lands on MAX_WAIT.
         if (in_grant && (ctr_at_max || ctr_count == CNT_W'(MAX_WAIT - 1))) begin
            timeout_err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (pick_i) begin
                  state_q        <= GRANT_I;
                  last_d_q       <= 1'b0;
                  pmem_read_q    <= 1'b1;
                  pmem_write_q   <= 1'b0;
                  pmem_address_q <= line_align(bus.i_address);
               end else if (pick_d) begin
                  state_q        <= GRANT_D;
                  last_d_q       <= 1'b1;
                  pmem_read_q    <= ~bus.d_write;
                  pmem_write_q   <= bus.d_write;
                  pmem_address_q <= line_align(bus.d_address);
                  pmem_wdata_q   <= bus.d_wdata;
               end
            end
            GRANT_I, GRANT_D: begin
               if (bus.pmem_resp) begin
                  state_q      <= IDLE;
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               pmem_read_q  <= 1'b0;
               pmem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = pmem_address_q;
   assign bus.pmem_wdata   = pmem_wdata_q;

   assign bus.i_resp  = (state_q == GRANT_I) & bus.pmem_resp;
   assign bus.d_resp  = (state_q == GRANT_D) & bus.pmem_resp;
   assign bus.i_rdata = bus.pmem_rdata;
   assign bus.d_rdata = bus.pmem_rdata;

   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

   localparam int LINE_W = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic timeout_err;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [LINE_W-1:0] pat_a5;
   logic [LINE_W-1:0] pat_rd;
   logic [LINE_W-1:0] pat_wd;

   mem_arbiter_if #(.LINE_W(LINE_W)) bus ();

   mem_arbiter #(
      .LINE_W   (LINE_W),
      .MAX_WAIT (255)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_read     = 1'b0;
      bus.i_address  = '0;
      bus.d_read     = 1'b0;
      bus.d_write    = 1'b0;
      bus.d_address  = '0;
      bus.d_wdata    = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   initial begin
      pat_a5 = {32{8'hA5}};
      pat_rd = {8{32'hCAFE_0000 + 32'h11}};
      pat_wd = {8{32'h1234_5678}};
      clear_inputs();
      #2;
      check("rst_pmem_read",  bus.pmem_read, 0);
      check("rst_pmem_write", bus.pmem_write, 0);
      check("rst_pmem_addr",  bus.pmem_address, 0);
      check("rst_pmem_wdata", bus.pmem_wdata, 0);
      check("rst_timeout",    timeout_err, 0);
      do_reset();

      // I-only read, response three cycles after grant
      bus.i_read = 1'b1; bus.i_address = 32'h0000_1234;
      tick();
      check("i_only_read",  bus.pmem_read, 1);
      check("i_only_write", bus.pmem_write, 0);
      check("i_only_addr",  bus.pmem_address, 32'h0000_1220);
      check("i_only_noresp", bus.i_resp, 0);
      repeat (2) tick();
      check("i_only_hold", bus.pmem_read, 1);
      bus.pmem_resp = 1'b1; bus.pmem_rdata = pat_rd;
      #1;
      check("i_only_resp",  bus.i_resp, 1);
      check("i_only_dresp", bus.d_resp, 0);
      check("i_only_rdata", bus.i_rdata, pat_rd);
      tick();
      bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
      check("i_only_drop", bus.pmem_read, 0);
      check("i_only_resp_end", bus.i_resp, 0);

      // Tie after reset: I first; I re-raised while D waits: D next
      do_reset();
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0104;
      bus.d_write = 1'b1; bus.d_address = 32'h0000_021F; bus.d_wdata = pat_wd;
      tick();
      check("tie1_addr", bus.pmem_address, 32'h0000_0100);
      check("tie1_read", bus.pmem_read, 1);
      bus.pmem_resp = 1'b1;
      #1;
      check("tie1_iresp", bus.i_resp, 1);
      check("tie1_dresp", bus.d_resp, 0);
      tick();
      bus.pmem_resp = 1'b0; bus.i_address = 32'h0000_0300;
      check("tie1_idle", bus.pmem_read | bus.pmem_write, 0);
      tick();
      check("tie2_write", bus.pmem_write, 1);
      check("tie2_read",  bus.pmem_read, 0);
      check("tie2_addr",  bus.pmem_address, 32'h0000_0200);
      check("tie2_wdata", bus.pmem_wdata, pat_wd);
      bus.pmem_resp = 1'b1;
      #1;
      check("tie2_dresp", bus.d_resp, 1);
      check("tie2_iresp", bus.i_resp, 0);
      tick();
      bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
      tick();
      check("tie3_addr", bus.pmem_address, 32'h0000_0300);
      check("tie3_read", bus.pmem_read, 1);
      bus.pmem_resp = 1'b1;
      tick();
      bus.pmem_resp = 1'b0; bus.i_read = 1'b0;

      // Read and write together: write wins
      bus.d_read = 1'b1; bus.d_write = 1'b1;
      bus.d_address = 32'h0000_0040; bus.d_wdata = pat_a5;
      tick();
      check("rw_write", bus.pmem_write, 1);
      check("rw_read",  bus.pmem_read, 0);
      check("rw_addr",  bus.pmem_address, 32'h0000_0040);
      check("rw_wdata", bus.pmem_wdata, pat_a5);
      bus.pmem_resp = 1'b1;
      #1;
      check("rw_dresp", bus.d_resp, 1);
      tick();
      bus.pmem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;

      // Request withdrawn mid-grant still completes
      bus.d_read = 1'b1; bus.d_address = 32'h0000_1000;
      tick();
      check("wd_read", bus.pmem_read, 1);
      bus.d_read = 1'b0;
      tick();
      check("wd_hold", bus.pmem_read, 1);
      bus.pmem_resp = 1'b1;
      #1;
      check("wd_dresp", bus.d_resp, 1);
      tick();
      bus.pmem_resp = 1'b0;
      check("wd_drop", bus.pmem_read, 0);

      // Timeout: 255 grant cycles without response
      bus.i_read = 1'b1; bus.i_address = 32'h0000_2000;
      tick();
      repeat (254) tick();
      check("to_before", timeout_err, 0);
      tick();
      check("to_set",  timeout_err, 1);
      check("to_wait", bus.pmem_read, 1);
      repeat (10) tick();
      check("to_sat", timeout_err, 1);
      bus.pmem_resp = 1'b1;
      #1;
      check("to_iresp", bus.i_resp, 1);
      tick();
      bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
      check("to_done",   bus.pmem_read, 0);
      check("to_sticky", timeout_err, 1);

      // Reset in the middle of a D grant
      do_reset();
      check("rst_clears_to", timeout_err, 0);
      bus.d_write = 1'b1; bus.d_address = 32'h0000_0080; bus.d_wdata = pat_wd;
      tick();
      check("mr_write", bus.pmem_write, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mr_async_write", bus.pmem_write, 0);
      check("mr_async_read",  bus.pmem_read, 0);
      check("mr_async_addr",  bus.pmem_address, 0);
      bus.d_write = 1'b0;
      tick();
      rst = 1'b1;
      bus.pmem_resp = 1'b1;
      #1;
      check("mr_stale_dresp", bus.d_resp, 0);
      tick();
      bus.pmem_resp = 1'b0;
      check("mr_stays_idle", bus.pmem_write | bus.pmem_read, 0);

      // Spurious response in IDLE
      bus.pmem_resp = 1'b1;
      #1;
      check("sp_iresp", bus.i_resp, 0);
      check("sp_dresp", bus.d_resp, 0);
      tick();
      bus.pmem_resp = 1'b0;
      check("sp_idle", bus.pmem_read | bus.pmem_write, 0);
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0ABC;
      tick();
      check("sp_grant_next", bus.pmem_read, 1);
      check("sp_grant_addr", bus.pmem_address, 32'h0000_0AA0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, sets the cache-line data width in bits.
REQ-002 Parameter MAX_WAIT, default 255, sets the grant-cycle count at which timeout_err sets.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_read  in  1  I-cache line-read request, level-held until i_resp.
REQ-006 i_address  in  32  I-side byte address.
REQ-007 i_rdata  out  LINE_W  I-side read line.
REQ-008 i_resp  out  1  I-side completion pulse.
REQ-009 d_read  in  1  D-cache line-read request, level-held until d_resp.
REQ-010 d_write  in  1  D-cache line-write request, level-held until d_resp.
REQ-011 d_address  in  32  D-side byte address.
REQ-012 d_wdata  in  LINE_W  D-side write line.
REQ-013 d_rdata  out  LINE_W  D-side read line.
REQ-014 d_resp  out  1  D-side completion pulse.
REQ-015 pmem_read  out  1  downstream read strobe, registered.
REQ-016 pmem_write  out  1  downstream write strobe, registered.
REQ-017 pmem_address  out  32  downstream line address, registered.
REQ-018 pmem_wdata  out  LINE_W  downstream write line, registered.
REQ-019 pmem_rdata  in  LINE_W  downstream read line.
REQ-020 pmem_resp  in  1  downstream completion, single-cycle pulse.
REQ-021 timeout_err  out  1  sticky error flag.

Function
REQ-022 The FSM SHALL have states IDLE, GRANT_I and GRANT_D.
REQ-023 In IDLE with only the I-side pending, the next edge SHALL enter GRANT_I; with only the D-side pending, it SHALL enter GRANT_D.
REQ-024 When both sides are pending in IDLE, the side not served last SHALL win (round-robin flag last_d).
REQ-025 At the granting edge, the block SHALL register the address with bits [4:0] zeroed and the strobe; for D it SHALL also register d_wdata. The strobe SHALL be visible the cycle after the request was first sampled.
REQ-026 If d_read and d_write are both high, write SHALL be issued and read ignored.
REQ-027 pmem_read/pmem_write SHALL stay high throughout GRANT_* until the edge sampling pmem_resp.
REQ-028 Strobes SHALL drop on that edge, and the FSM SHALL return to IDLE.
REQ-029 i_resp SHALL equal pmem_resp while in GRANT_I, and 0 otherwise; d_resp likewise for GRANT_D.
REQ-030 i_rdata and d_rdata SHALL equal pmem_rdata combinationally.
REQ-031 Requester responses SHALL have zero added latency.
REQ-032 A request withdrawn mid-grant SHALL NOT abort the transaction; it completes and the resp pulse is still driven.
REQ-033 Back-to-back: from IDLE the cycle after a completion, a pending request SHALL be granted on the next edge; arbitration SHALL use the updated last_d.
REQ-034 last_d SHALL update at grant: 1 for D, 0 for I.
REQ-035 A wait counter SHALL clear at each grant and increment once per GRANT_* cycle.
REQ-036 The counter SHALL saturate at MAX_WAIT, and timeout_err SHALL set when it reaches MAX_WAIT.
REQ-037 timeout_err SHALL stay set until reset; the transaction keeps waiting.
REQ-038 pmem_resp in IDLE SHALL be ignored: no requester resp, no state change.

Reset
REQ-039 rst low SHALL asynchronously force state=IDLE, last_d=1 (I wins first tie), counter=0, timeout_err=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
REQ-040 Reset mid-grant SHALL drop strobes immediately, and no resp SHALL follow for the aborted transaction.

Structure
REQ-041 The state enum arb_state_t and the line-offset width constant SHALL live in the shared rv32i_types package.
REQ-042 The wait counter SHALL be the sub-module arb_wait_ctr, with inputs clr/en and outputs count/at_max.

Verification
REQ-043 I-only read at 0x0000_1234: the next cycle pmem_read=1 and pmem_address=0x0000_1220; pmem_resp 3 cycles later gives i_resp=1 for one cycle with i_rdata=pmem_rdata, then IDLE.
REQ-044 i_read and d_write raised together after reset: I is served first, then D. Both raised again: D is served first.
REQ-045 d_read=d_write=1 at 0x40, d_wdata=0xA5..: pmem_write=1 with that data, pmem_read=0.
REQ-046 Grant with pmem_resp withheld for 255 cycles: timeout_err=1 and remains 1 after the late pmem_resp completes the transaction.
REQ-047 rst low during GRANT_D: strobes are 0 asynchronously, and after release no d_resp is issued for a stale pmem_resp.
REQ-048 Spurious pmem_resp in IDLE: i_resp=d_resp=0 and the state is unchanged.
